// File: rtl/cmd_card_responder.sv
// cmd_card_responder: SD card-side CMD line receiver with CRC7 check and R1/R2-style response transmitter
module cmd_card_responder #(
  parameter int NCR          = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         cmd_in,
  output logic         cmd_out,
  output logic         cmd_oe,
  output logic         cmd_valid,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_arg,
  output logic         crc_error,
  input  logic         resp_strobe,
  input  logic         resp_skip,
  input  logic         resp_long,
  input  logic [127:0] resp_data,
  output logic         resp_ack,
  output logic         no_resp,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, RECV, CHECK, WAIT_APP, NCR_WAIT, SEND, DONE} state_t;
  localparam logic [15:0] TO_LAST  = 16'(RESP_TIMEOUT - 1);
  localparam logic [15:0] NCR_LAST = 16'(NCR - 1);
  state_t       r_state, w_next;
  logic [15:0]  r_cnt;
  logic [47:0]  r_rx;
  logic [135:0] r_tx;
  logic [6:0]   r_crc;
  logic         r_long, r_no_resp;
  logic         w_frame_ok, w_send_last, w_crc_phase;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    crc7_step = {c[5:0], 1'b0} ^ ((c[6] ^ b) ? 7'h09 : 7'h00);
  endfunction

  // start bit is always 0 here by construction; the term keeps the frame check complete
  assign w_frame_ok  = !r_rx[47] && r_rx[46] && r_rx[0] && (r_rx[7:1] == r_crc);
  assign w_send_last = r_cnt == (r_long ? 16'd135 : 16'd47);
  // short responses replace bits 40..46 with the CRC computed on the fly
  assign w_crc_phase = !r_long && r_cnt >= 16'd40 && r_cnt < 16'd47;
  assign busy        = r_state != IDLE;
  assign no_resp     = r_no_resp;

  // state register
  always_ff @(posedge sd_clock or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;

  // next-state decode and per-state outputs
  always_comb begin
    w_next    = r_state;
    cmd_valid = 1'b0;
    crc_error = 1'b0;
    resp_ack  = 1'b0;
    cmd_oe    = 1'b0;
    cmd_out   = 1'b1;
    case (r_state)
      IDLE:     w_next = cmd_in ? IDLE : RECV;
      RECV:     w_next = (r_cnt == 16'd47) ? CHECK : RECV;
      CHECK: begin
        cmd_valid = w_frame_ok;
        crc_error = !w_frame_ok;
        w_next    = w_frame_ok ? WAIT_APP : IDLE;
      end
      WAIT_APP: w_next = resp_skip ? IDLE : resp_strobe ? NCR_WAIT : (r_cnt == TO_LAST) ? IDLE : WAIT_APP;
      NCR_WAIT: w_next = (r_cnt == NCR_LAST) ? SEND : NCR_WAIT;
      SEND: begin
        cmd_oe  = 1'b1;
        cmd_out = w_crc_phase ? r_crc[6] : r_tx[135];
        w_next  = w_send_last ? DONE : SEND;
      end
      DONE: begin
        resp_ack = 1'b1;
        w_next   = IDLE;
      end
      default:  w_next = IDLE;
    endcase
  end

  // datapath: bit counter, receive shifter, shared CRC7, response shifter and decoded command
  always_ff @(posedge sd_clock or negedge reset)
    if (!reset) begin
      r_cnt     <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_crc     <= '0;
      r_long    <= 1'b0;
      r_no_resp <= 1'b0;
      cmd_index <= '0;
      cmd_arg   <= '0;
    end else begin
      r_no_resp <= r_state == WAIT_APP && w_next == IDLE && !resp_skip;
      r_cnt     <= (r_state == IDLE && w_next == RECV) ? 16'd1 : (r_state != w_next) ? 16'd0 : r_cnt + 16'd1;
      r_rx      <= (r_state == RECV) ? {r_rx[46:0], cmd_in} : (r_state == IDLE) ? 48'd0 : r_rx;
      r_crc     <= (r_state == RECV) ? ((r_cnt < 16'd40) ? crc7_step(r_crc, cmd_in) : r_crc)
                 : (r_state == SEND) ? ((r_cnt < 16'd40) ? crc7_step(r_crc, r_tx[135]) : {r_crc[5:0], 1'b0})
                 : 7'd0;
      if (r_state == CHECK && w_frame_ok) begin
        cmd_index <= r_rx[45:40];
        cmd_arg   <= r_rx[39:8];
      end
      if (r_state == WAIT_APP && w_next == NCR_WAIT) begin
        r_long <= resp_long;
        r_tx   <= resp_long ? {2'b00, 6'h3F, resp_data[127:1], 1'b1} : {2'b00, resp_data[37:0], 8'h01, 88'd0};
      end else if (r_state == SEND) r_tx <= {r_tx[134:0], 1'b0};
    end
endmodule

// File: tb/tb_cmd_card_responder.sv
// tb_cmd_card_responder: directed vector table plus hand-written response sequences
module tb_cmd_card_responder;
  logic         clk, rst_n, cmd_in, resp_strobe, resp_skip, resp_long;
  logic [127:0] resp_data;
  logic         cmd_out, cmd_oe, cmd_valid, crc_error, resp_ack, no_resp, busy;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  int           vec_n = 0, err_n = 0;
  int           oe_n = 0, ack_n = 0, nr_n = 0;
  logic [135:0] rx_bits = '0;

  cmd_card_responder #(.NCR(2), .RESP_TIMEOUT(64)) dut (
    .sd_clock(clk), .reset(rst_n), .cmd_in(cmd_in), .cmd_out(cmd_out), .cmd_oe(cmd_oe),
    .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_arg(cmd_arg), .crc_error(crc_error),
    .resp_strobe(resp_strobe), .resp_skip(resp_skip), .resp_long(resp_long), .resp_data(resp_data),
    .resp_ack(resp_ack), .no_resp(no_resp), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_oe) begin
      oe_n++;
      rx_bits = {rx_bits[134:0], cmd_out};
    end
    if (resp_ack) ack_n++;
    if (no_resp) nr_n++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [47:0] frame;
    logic        ok;
    logic [5:0]  idx;
    logic [31:0] arg;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    vec_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      cmd_in = f[i];
      @(posedge clk); #1;
    end
    cmd_in = 1'b1;
  endtask

  task automatic wait_ack(input int lim, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (resp_ack) seen = 1'b1;
    end
  endtask

  initial begin
    int           oe0, ack0, nr0;
    bit           seen;
    logic [135:0] exp_long;
    tbl[0] = '{48'h400000000095, 1'b1, 6'd0,  32'h00000000};
    tbl[1] = '{48'h48000001AA87, 1'b1, 6'd8,  32'h000001AA};
    tbl[2] = '{48'h48000001AA86, 1'b0, 6'd8,  32'h000001AA};
    tbl[3] = '{48'h48000001AB87, 1'b0, 6'd8,  32'h000001AA};
    tbl[4] = '{48'h770000000065, 1'b1, 6'd55, 32'h00000000};
    tbl[5] = '{48'h08000001AA87, 1'b0, 6'd55, 32'h00000000};
    tbl[6] = '{48'h7A00000000FD, 1'b1, 6'd58, 32'h00000000};
    tbl[7] = '{48'h400000000097, 1'b0, 6'd58, 32'h00000000};
    rst_n = 1'b0; cmd_in = 1'b1; resp_strobe = 1'b0; resp_skip = 1'b0; resp_long = 1'b0; resp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 136'({cmd_out, cmd_oe, cmd_valid, crc_error, resp_ack, no_resp, busy}), 136'(7'b1000000));
    chk("reset_index_arg", 136'({cmd_index, cmd_arg}), 136'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    oe0 = oe_n;
    for (int v = 0; v < 8; v++) begin
      send_cmd(tbl[v].frame);
      @(negedge clk);
      chk($sformatf("v%0d_valid_crcerr", v), 136'({cmd_valid, crc_error}), 136'({tbl[v].ok, !tbl[v].ok}));
      @(posedge clk); #1;
      if (tbl[v].ok) begin
        resp_skip = 1'b1;
        @(posedge clk); #1;
        resp_skip = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy_noresp", v), 136'({busy, no_resp}), 136'd0);
      chk($sformatf("v%0d_index_arg", v), 136'({cmd_index, cmd_arg}), 136'({tbl[v].idx, tbl[v].arg}));
      @(posedge clk); #1;
    end
    chk("table_no_oe", 136'(oe_n - oe0), 136'd0);

    send_cmd(48'h48000001AA87);
    @(negedge clk);
    chk("cmd8_valid", 136'(cmd_valid), 136'd1);
    @(posedge clk); #1;
    oe0 = oe_n; ack0 = ack_n;
    resp_long = 1'b0; resp_data = {90'd0, 6'd8, 32'h000001AA}; resp_strobe = 1'b1;
    @(posedge clk); #1;
    resp_strobe = 1'b0;
    @(negedge clk);
    chk("ncr_cycle0_oe", 136'(cmd_oe), 136'd0);
    chk("cmd8_index_arg", 136'({cmd_index, cmd_arg}), 136'({6'd8, 32'h000001AA}));
    @(negedge clk);
    chk("ncr_cycle1_oe", 136'(cmd_oe), 136'd0);
    @(negedge clk);
    chk("start_bit", 136'({cmd_oe, cmd_out}), 136'(2'b10));
    wait_ack(200, seen);
    chk("short_ack_seen", 136'(seen), 136'd1);
    chk("done_line", 136'({cmd_oe, cmd_out}), 136'(2'b01));
    #1;
    chk("short_oe_cycles", 136'(oe_n - oe0), 136'd48);
    chk("short_frame", 136'(rx_bits[47:0]), 136'(48'h08000001AA13));
    chk("short_ack_count", 136'(ack_n - ack0), 136'd1);
    @(posedge clk); #1;

    send_cmd(48'h48000001AA87);
    @(negedge clk);
    chk("to_valid", 136'(cmd_valid), 136'd1);
    oe0 = oe_n; nr0 = nr_n;
    @(posedge clk);
    repeat (63) @(posedge clk);
    @(negedge clk);
    chk("to_before_expiry", 136'({no_resp, busy}), 136'(2'b01));
    @(posedge clk);
    @(negedge clk);
    chk("to_expiry", 136'({no_resp, busy}), 136'(2'b10));
    @(negedge clk);
    chk("to_single_pulse", 136'(no_resp), 136'd0);
    chk("to_no_oe", 136'(oe_n - oe0), 136'd0);
    chk("to_pulse_count", 136'(nr_n - nr0), 136'd1);
    @(posedge clk); #1;

    send_cmd(48'h770000000065);
    @(negedge clk);
    chk("long_cmd_valid", 136'(cmd_valid), 136'd1);
    @(posedge clk); #1;
    oe0 = oe_n;
    resp_long = 1'b1; resp_data = 128'hFFEEDDCCBBAA99887766554433221100; resp_strobe = 1'b1;
    exp_long = {2'b00, 6'h3F, resp_data[127:1], 1'b1};
    @(posedge clk); #1;
    resp_strobe = 1'b0; resp_long = 1'b0; resp_data = '0;
    wait_ack(300, seen);
    chk("long_ack_seen", 136'(seen), 136'd1);
    #1;
    chk("long_oe_cycles", 136'(oe_n - oe0), 136'd136);
    chk("long_frame", rx_bits, exp_long);
    @(posedge clk); #1;

    send_cmd(48'h400000000095);
    @(posedge clk); #1;
    oe0 = oe_n; ack0 = ack_n; nr0 = nr_n;
    resp_strobe = 1'b1; resp_skip = 1'b1;
    @(posedge clk); #1;
    resp_strobe = 1'b0; resp_skip = 1'b0;
    @(negedge clk);
    chk("skip_prio_idle", 136'(busy), 136'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("skip_prio_no_resp", 136'({32'(oe_n - oe0), 32'(ack_n - ack0), 32'(nr_n - nr0)}), 136'd0);

    send_cmd(48'h48000001AA87);
    @(posedge clk); #1;
    resp_long = 1'b0; resp_data = {90'd0, 6'd8, 32'h000001AA}; resp_strobe = 1'b1;
    @(posedge clk); #1;
    resp_strobe = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (cmd_oe) seen = 1'b1;
    end
    chk("rst_send_started", 136'(seen), 136'd1);
    repeat (20) @(negedge clk);
    chk("rst_bit20_oe", 136'(cmd_oe), 136'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_abort_outputs", 136'({cmd_oe, cmd_out, busy}), 136'(3'b010));
    chk("rst_clears_index", 136'({cmd_index, cmd_arg}), 136'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_cmd(48'h400000000095);
    @(negedge clk);
    chk("post_rst_cmd0", 136'({cmd_valid, crc_error}), 136'(2'b10));
    @(posedge clk); #1;
    resp_skip = 1'b1;
    @(posedge clk); #1;
    resp_skip = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 136'({busy, cmd_oe, cmd_index, cmd_arg}), 136'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end
endmodule
